apb_fsm_controller: RTL and testbench

- Downstream stage of the AHB slave interface in the AHB-to-APB bridge.
- Consumes the decoded transfer request: valid, Hwrite/Hwritereg, the current and pipelined addresses and write data, and tempselx.
- Sequences APB SETUP and ENABLE phases on the peripheral side.
- Produces Hreadyout, which stalls the AHB master while an APB access is outstanding.

---
 rtl/apb_fsm_controller_if.sv | 31 +++
 rtl/apb_fsm_controller.sv | 76 +++++++
 tb/tb_apb_fsm_controller.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_fsm_controller_if.sv
// apb_fsm_controller_if: decoded AHB transfer request in, APB setup/enable phases out.
interface apb_fsm_controller_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              valid;
    logic              Hwrite;
    logic              Hwritereg;
    logic [ADDR_W-1:0] Haddr;
    logic [ADDR_W-1:0] Haddr1;
    logic [ADDR_W-1:0] Haddr2;
    logic [DATA_W-1:0] Hwdata;
    logic [DATA_W-1:0] Hwdata1;
    logic [2:0]        tempselx;
    logic [2:0]        Pselx;
    logic              Penable;
    logic              Pwrite;
    logic [ADDR_W-1:0] Paddr;
    logic [DATA_W-1:0] Pwdata;
    logic              Hreadyout;

    modport master (
        output valid, Hwrite, Hwritereg, Haddr, Haddr1, Haddr2, Hwdata, Hwdata1, tempselx,
        input  Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout
    );

    modport slave (
        input  valid, Hwrite, Hwritereg, Haddr, Haddr1, Haddr2, Hwdata, Hwdata1, tempselx,
        output Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout
    );
endinterface

// File: rtl/apb_fsm_controller.sv
// apb_fsm_controller: sequences APB SETUP/ENABLE phases for the AHB-to-APB bridge
// and stalls the AHB master via Hreadyout while an access is outstanding.
module apb_fsm_controller (
    input logic                 Hclk,
    input logic                 Hresetn,
    apb_fsm_controller_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, WWAIT, WRITE, WRITEP, RENABLE, WENABLE, WENABLEP} state_t;

    state_t     state;
    logic [2:0] sel1, sel2;

    assign bus.Hreadyout = !(state == READ || state == WRITEP);

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state       <= IDLE;
            sel1        <= '0;
            sel2        <= '0;
            bus.Pselx   <= '0;
            bus.Penable <= 1'b0;
            bus.Pwrite  <= 1'b0;
            bus.Paddr   <= '0;
            bus.Pwdata  <= '0;
        end else begin
            sel1 <= bus.tempselx;
            sel2 <= sel1;
            case (state)
                IDLE, RENABLE, WENABLE: begin
                    bus.Penable <= 1'b0;
                    if (bus.valid && !bus.Hwrite) begin
                        state      <= READ;
                        bus.Pselx  <= bus.tempselx;
                        bus.Paddr  <= bus.Haddr;
                        bus.Pwrite <= 1'b0;
                    end else begin
                        state     <= bus.valid ? WWAIT : IDLE;
                        bus.Pselx <= '0;
                    end
                end
                WWAIT: begin
                    state       <= bus.valid ? WRITEP : WRITE;
                    bus.Pselx   <= sel1;
                    bus.Paddr   <= bus.Haddr1;
                    bus.Pwdata  <= bus.Hwdata;
                    bus.Pwrite  <= 1'b1;
                    bus.Penable <= 1'b0;
                end
                READ: begin
                    state       <= RENABLE;
                    bus.Penable <= 1'b1;
                end
                WRITE: begin
                    state       <= bus.valid ? WENABLEP : WENABLE;
                    bus.Penable <= 1'b1;
                end
                WRITEP: begin
                    state       <= WENABLEP;
                    bus.Penable <= 1'b1;
                end
                WENABLEP: begin
                    // pipelined request is two cycles old here, so use the doubly delayed copies
                    bus.Pselx   <= sel2;
                    bus.Paddr   <= bus.Haddr2;
                    bus.Penable <= 1'b0;
                    bus.Pwrite  <= bus.Hwritereg;
                    if (!bus.Hwritereg) state <= READ;
                    else begin
                        state      <= bus.valid ? WRITEP : WRITE;
                        bus.Pwdata <= bus.Hwdata1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_fsm_controller.sv
// tb_apb_fsm_controller: directed test-plan steps plus randomized traffic checked
// against a transfer-rule reference model.
module tb_apb_fsm_controller;
    logic Hclk = 1'b0;
    logic Hresetn;
    int   n_vec = 0;
    int   n_err = 0;

    apb_fsm_controller_if #(.ADDR_W(32), .DATA_W(32)) bus();

    apb_fsm_controller dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .bus     (bus.slave)
    );

    always #5 Hclk = ~Hclk;

    // AHB slave-interface pipeline registers feeding the controller
    logic [2:0] s1, s2;
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            bus.Hwritereg <= 1'b0;
            bus.Haddr1    <= '0;
            bus.Haddr2    <= '0;
            bus.Hwdata1   <= '0;
            s1            <= '0;
            s2            <= '0;
        end else begin
            bus.Hwritereg <= bus.Hwrite;
            bus.Haddr1    <= bus.Haddr;
            bus.Haddr2    <= bus.Haddr1;
            bus.Hwdata1   <= bus.Hwdata;
            s1            <= bus.tempselx;
            s2            <= s1;
        end
    end

    localparam int M_IDLE = 0, M_READ = 1, M_WWAIT = 2, M_WRITE = 3, M_WRITEP = 4,
                   M_RENABLE = 5, M_WENABLE = 6, M_WENABLEP = 7;

    int          ms;
    logic [2:0]  m_sel;
    logic        m_en, m_wr;
    logic [31:0] m_addr, m_wdata;

    function automatic logic [2:0] dec(input logic [31:0] a);
        return a[31:26] == 6'b100000 ? 3'b001 :
               a[31:26] == 6'b100001 ? 3'b010 :
               a[31:26] == 6'b100010 ? 3'b100 : 3'b000;
    endfunction

    function automatic int nxt(input int s, input logic v, input logic w, input logic wr);
        if (s == M_READ) return M_RENABLE;
        if (s == M_WRITEP) return M_WENABLEP;
        if (s == M_WWAIT) return v ? M_WRITEP : M_WRITE;
        if (s == M_WRITE) return v ? M_WENABLEP : M_WENABLE;
        if (s == M_WENABLEP) return !wr ? M_READ : (v ? M_WRITEP : M_WRITE);
        return v ? (w ? M_WWAIT : M_READ) : M_IDLE;
    endfunction

    task automatic model_reset();
        ms = M_IDLE; m_sel = '0; m_en = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
    endtask

    task automatic model_edge();
        int n;
        n = nxt(ms, bus.valid, bus.Hwrite, bus.Hwritereg);
        if (n == M_RENABLE || n == M_WENABLE || n == M_WENABLEP) m_en = 1;
        else if (n == M_IDLE || n == M_WWAIT) begin
            m_sel = '0; m_en = 0;
        end else if (n == M_READ) begin
            m_en = 0; m_wr = 0;
            m_sel  = (ms == M_WENABLEP) ? s2 : bus.tempselx;
            m_addr = (ms == M_WENABLEP) ? bus.Haddr2 : bus.Haddr;
        end else begin
            m_en = 0; m_wr = 1;
            m_sel   = (ms == M_WWAIT) ? s1 : s2;
            m_addr  = (ms == M_WWAIT) ? bus.Haddr1 : bus.Haddr2;
            m_wdata = (ms == M_WWAIT) ? bus.Hwdata : bus.Hwdata1;
        end
        ms = n;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_model();
        chk("m_pselx",   32'(bus.Pselx),     32'(m_sel));
        chk("m_penable", 32'(bus.Penable),   32'(m_en));
        chk("m_pwrite",  32'(bus.Pwrite),    32'(m_wr));
        chk("m_paddr",   bus.Paddr,          m_addr);
        chk("m_pwdata",  bus.Pwdata,         m_wdata);
        chk("m_hready",  32'(bus.Hreadyout), 32'(!(ms == M_READ || ms == M_WRITEP)));
    endtask

    task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.valid = v; bus.Hwrite = w; bus.Haddr = a; bus.Hwdata = d; bus.tempselx = dec(a);
        model_edge();
        @(posedge Hclk);
        #1;
        chk_model();
    endtask

    function automatic logic [31:0] rnd_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 15) return 32'h9000_0000 | ($urandom & 32'h00FF_FFFC);
        return 32'h8000_0000 + (32'(r % 3) << 26) + ($urandom & 32'h03FF_FFFC);
    endfunction

    initial begin
        Hresetn = 0;
        bus.valid = 0; bus.Hwrite = 0; bus.Haddr = '0; bus.Hwdata = '0; bus.tempselx = '0;
        model_reset();
        repeat (2) @(posedge Hclk);
        #1;
        chk("rst_pselx", 32'(bus.Pselx), 32'h0);
        chk("rst_hready", 32'(bus.Hreadyout), 32'h1);
        chk("rst_paddr", bus.Paddr, 32'h0);
        @(negedge Hclk) Hresetn = 1;

        // reset in the middle of a write aborts at once
        step(1, 1, 32'h8000_0040, 32'h0);
        step(0, 0, 32'h0, 32'h1234_5678);
        chk("t1_setup_pselx", 32'(bus.Pselx), 32'h1);
        Hresetn = 0;
        #1;
        model_reset();
        chk("t1_rst_pselx", 32'(bus.Pselx), 32'h0);
        chk("t1_rst_penable", 32'(bus.Penable), 32'h0);
        chk("t1_rst_hready", 32'(bus.Hreadyout), 32'h1);
        @(negedge Hclk) Hresetn = 1;
        step(0, 0, 32'h0, 32'h0);
        chk("t1_idle_pselx", 32'(bus.Pselx), 32'h0);
        chk("t1_idle_hready", 32'(bus.Hreadyout), 32'h1);

        // single read
        step(1, 0, 32'h8000_0010, 32'h0);
        chk("t2_pselx", 32'(bus.Pselx), 32'h1);
        chk("t2_paddr", bus.Paddr, 32'h8000_0010);
        chk("t2_pwrite", 32'(bus.Pwrite), 32'h0);
        chk("t2_penable", 32'(bus.Penable), 32'h0);
        chk("t2_hready", 32'(bus.Hreadyout), 32'h0);
        step(0, 0, 32'h0, 32'h0);
        chk("t2_en_penable", 32'(bus.Penable), 32'h1);
        chk("t2_en_hready", 32'(bus.Hreadyout), 32'h1);
        step(0, 0, 32'h0, 32'h0);
        chk("t2_idle_pselx", 32'(bus.Pselx), 32'h0);

        // single write
        step(1, 1, 32'h8400_0020, 32'h0);
        chk("t3_wwait_pselx", 32'(bus.Pselx), 32'h0);
        step(0, 0, 32'h0, 32'hDEAD_BEEF);
        chk("t3_pselx", 32'(bus.Pselx), 32'h2);
        chk("t3_paddr", bus.Paddr, 32'h8400_0020);
        chk("t3_pwdata", bus.Pwdata, 32'hDEAD_BEEF);
        chk("t3_pwrite", 32'(bus.Pwrite), 32'h1);
        step(0, 0, 32'h0, 32'h0);
        chk("t3_penable", 32'(bus.Penable), 32'h1);
        step(0, 0, 32'h0, 32'h0);

        // pipelined writes; master holds A2 while stalled
        step(1, 1, 32'h8000_0004, 32'h0);
        step(1, 1, 32'h8800_0008, 32'h11);
        chk("t4_p_hready", 32'(bus.Hreadyout), 32'h0);
        chk("t4_p_paddr", bus.Paddr, 32'h8000_0004);
        chk("t4_p_pwdata", bus.Pwdata, 32'h11);
        chk("t4_p_pselx", 32'(bus.Pselx), 32'h1);
        step(0, 1, 32'h8800_0008, 32'h22);
        chk("t4_ep_penable", 32'(bus.Penable), 32'h1);
        step(0, 0, 32'h0, 32'h0);
        chk("t4_w_paddr", bus.Paddr, 32'h8800_0008);
        chk("t4_w_pwdata", bus.Pwdata, 32'h22);
        chk("t4_w_pselx", 32'(bus.Pselx), 32'h4);
        step(0, 0, 32'h0, 32'h0);
        chk("t4_we_penable", 32'(bus.Penable), 32'h1);
        step(0, 0, 32'h0, 32'h0);

        // write then read
        step(1, 1, 32'h8000_0000, 32'h0);
        step(1, 0, 32'h8400_0000, 32'h55);
        step(0, 0, 32'h8400_0000, 32'h0);
        chk("t5_ep_penable", 32'(bus.Penable), 32'h1);
        step(0, 0, 32'h0, 32'h0);
        chk("t5_r_paddr", bus.Paddr, 32'h8400_0000);
        chk("t5_r_pselx", 32'(bus.Pselx), 32'h2);
        chk("t5_r_pwrite", 32'(bus.Pwrite), 32'h0);
        chk("t5_r_penable", 32'(bus.Penable), 32'h0);
        step(0, 0, 32'h0, 32'h0);
        chk("t5_re_penable", 32'(bus.Penable), 32'h1);
        step(0, 0, 32'h0, 32'h0);

        // back-to-back reads
        step(1, 0, 32'h8000_0000, 32'h0);
        chk("t6_r1_paddr", bus.Paddr, 32'h8000_0000);
        step(1, 0, 32'h8000_0004, 32'h0);
        chk("t6_e1_penable", 32'(bus.Penable), 32'h1);
        step(1, 0, 32'h8000_0004, 32'h0);
        chk("t6_r2_paddr", bus.Paddr, 32'h8000_0004);
        chk("t6_r2_penable", 32'(bus.Penable), 32'h0);
        chk("t6_r2_hready", 32'(bus.Hreadyout), 32'h0);
        step(0, 0, 32'h0, 32'h0);
        chk("t6_e2_penable", 32'(bus.Penable), 32'h1);
        step(0, 0, 32'h0, 32'h0);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), rnd_addr(), $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
